// File: rtl/mmp_dac_rx.sv
// Serial DAC receiver: recovers four 16-bit signed samples (SCC/ALL on the right
// word, PSG/OPLL on the left word) from two left-justified serial lines.
module mmp_dac_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_DAC_CLK,
  input  logic                 i_DAC_WS,
  input  logic                 i_DAC1_L_R,
  input  logic                 i_DAC2_L_R,
  output logic [WORD_BITS-1:0] o_SCC,
  output logic [WORD_BITS-1:0] o_PSG,
  output logic [WORD_BITS-1:0] o_OPLL,
  output logic [WORD_BITS-1:0] o_ALL,
  output logic                 o_VALID_R,
  output logic                 o_VALID_L,
  output logic                 o_FRAME_ERR
);

  localparam int CNT_W = $clog2(WORD_BITS + 2);

  typedef enum logic [1:0] {HUNT, SHIFT, WAIT} state_e;

  // Synchronizer lanes: [3]=bit clock, [2]=word select, [1]=line 1, [0]=line 2.
  logic [3:0] sync_q [SYNC_STAGES];

  // NOTE: the synchronizer is an array of flops, not RAM, so every element is reset.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {i_DAC_CLK, i_DAC_WS, i_DAC1_L_R, i_DAC2_L_R};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic dac_clk_s, ws_s, sd1_s, sd2_s;
  assign {dac_clk_s, ws_s, sd1_s, sd2_s} = sync_q[SYNC_STAGES-1];

  state_e               state_q;
  logic                 dac_clk_prev_q;
  logic                 ws_prev_q;
  logic                 ws_seen_q;
  logic                 ws_word_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_BITS-2:0] sh1_q, sh2_q;
  logic [WORD_BITS-1:0] scc_q, psg_q, opll_q, all_q;
  logic                 valid_r_q, valid_l_q, frame_err_q;

  logic                 bit_evt, ws_chg;
  logic [WORD_BITS-1:0] word1_d, word2_d;

  assign bit_evt = dac_clk_s & ~dac_clk_prev_q;
  // The first bit event after reset only learns WS; it cannot mark a word start.
  assign ws_chg  = ws_seen_q & (ws_s ^ ws_prev_q);
  assign word1_d = {sh1_q, sd1_s};
  assign word2_d = {sh2_q, sd2_s};

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q        <= HUNT;
      dac_clk_prev_q <= 1'b0;
      ws_prev_q      <= 1'b0;
      ws_seen_q      <= 1'b0;
      ws_word_q      <= 1'b0;
      cnt_q          <= '0;
      sh1_q          <= '0;
      sh2_q          <= '0;
      scc_q          <= '0;
      psg_q          <= '0;
      opll_q         <= '0;
      all_q          <= '0;
      valid_r_q      <= 1'b0;
      valid_l_q      <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      dac_clk_prev_q <= dac_clk_s;
      valid_r_q      <= 1'b0;
      valid_l_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      if (bit_evt) begin
        ws_prev_q <= ws_s;
        ws_seen_q <= 1'b1;
        if (ws_chg) begin
          // A word still in SHIFT at a WS change is short and gets dropped.
          frame_err_q <= (state_q == SHIFT);
          sh1_q       <= {{(WORD_BITS-2){1'b0}}, sd1_s};
          sh2_q       <= {{(WORD_BITS-2){1'b0}}, sd2_s};
          ws_word_q   <= ws_s;
          cnt_q       <= CNT_W'(1);
          state_q     <= SHIFT;
        end else begin
          case (state_q)
            SHIFT: begin
              sh1_q <= word1_d[WORD_BITS-2:0];
              sh2_q <= word2_d[WORD_BITS-2:0];
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
                state_q <= WAIT;
                if (ws_word_q) begin
                  psg_q     <= word1_d;
                  opll_q    <= word2_d;
                  valid_l_q <= 1'b1;
                end else begin
                  scc_q     <= word1_d;
                  all_q     <= word2_d;
                  valid_r_q <= 1'b1;
                end
              end
            end
            WAIT: begin
              // Count parks one past the word length so only the first extra bit flags.
              if (cnt_q == CNT_W'(WORD_BITS)) begin
                frame_err_q <= 1'b1;
                cnt_q       <= cnt_q + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_SCC       = scc_q;
  assign o_PSG       = psg_q;
  assign o_OPLL      = opll_q;
  assign o_ALL       = all_q;
  assign o_VALID_R   = valid_r_q;
  assign o_VALID_L   = valid_l_q;
  assign o_FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_mmp_dac_rx.sv
// Bench for mmp_dac_rx: a word-level transmitter model predicts the ordered
// stream of commits and frame errors; a monitor records what the DUT produced.
module tb_mmp_dac_rx;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  localparam logic [1:0] K_R   = 2'd0;
  localparam logic [1:0] K_L   = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_DAC_CLK = 1'b0;
  logic        i_DAC_WS = 1'b0;
  logic        i_DAC1_L_R = 1'b0;
  logic        i_DAC2_L_R = 1'b0;
  logic [15:0] o_SCC, o_PSG, o_OPLL, o_ALL;
  logic        o_VALID_R, o_VALID_L, o_FRAME_ERR;

  int total = 0;
  int bad = 0;
  int overlap_cnt = 0;

  ev_t got_q[$];
  ev_t exp_q[$];

  // Word-level reference state.
  logic        m_vld = 1'b0;
  logic        m_prev_ws = 1'b0;
  logic        m_pend_short = 1'b0;
  logic [15:0] m_scc = 16'h0, m_psg = 16'h0, m_opll = 16'h0, m_all = 16'h0;

  mmp_dac_rx #(.SYNC_STAGES(2), .WORD_BITS(16)) dut (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_DAC_CLK   (i_DAC_CLK),
    .i_DAC_WS    (i_DAC_WS),
    .i_DAC1_L_R  (i_DAC1_L_R),
    .i_DAC2_L_R  (i_DAC2_L_R),
    .o_SCC       (o_SCC),
    .o_PSG       (o_PSG),
    .o_OPLL      (o_OPLL),
    .o_ALL       (o_ALL),
    .o_VALID_R   (o_VALID_R),
    .o_VALID_L   (o_VALID_L),
    .o_FRAME_ERR (o_FRAME_ERR)
  );

  always #5 i_CLK = ~i_CLK;

  always @(posedge i_CLK) begin
    #1;
    if (o_VALID_R)   got_q.push_back(ev_t'{K_R, o_SCC, o_ALL});
    if (o_VALID_L)   got_q.push_back(ev_t'{K_L, o_PSG, o_OPLL});
    if (o_FRAME_ERR) got_q.push_back(ev_t'{K_ERR, 16'h0, 16'h0});
    if (int'(o_VALID_R) + int'(o_VALID_L) + int'(o_FRAME_ERR) > 1) overlap_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One DAC_CLK period: data changes with the falling edge, ratio i_CLK cycles long.
  task automatic send_bit(input logic w, input logic b1, input logic b2, input int ratio);
    @(negedge i_CLK);
    i_DAC_CLK  = 1'b0;
    i_DAC_WS   = w;
    i_DAC1_L_R = b1;
    i_DAC2_L_R = b2;
    repeat (ratio / 2) @(negedge i_CLK);
    i_DAC_CLK = 1'b1;
    repeat (ratio / 2 - 1) @(negedge i_CLK);
  endtask

  task automatic tx_word(input logic w, input logic [15:0] w1, input logic [15:0] w2,
                         input int nbits, input int ratio);
    logic framed;
    framed = m_vld && (w != m_prev_ws);
    if (framed && m_pend_short) exp_q.push_back(ev_t'{K_ERR, 16'h0, 16'h0});
    m_pend_short = 1'b0;
    if (framed) begin
      if (nbits >= 16) begin
        exp_q.push_back(ev_t'{(w ? K_L : K_R), w1, w2});
        if (w) begin m_psg = w1; m_opll = w2; end
        else   begin m_scc = w1; m_all  = w2; end
      end
      if (nbits > 16) exp_q.push_back(ev_t'{K_ERR, 16'h0, 16'h0});
      if (nbits < 16) m_pend_short = 1'b1;
    end
    m_prev_ws = w;
    m_vld = 1'b1;
    for (int i = 0; i < nbits; i++)
      send_bit(w, (i < 16) ? w1[15-i] : 1'b0, (i < 16) ? w2[15-i] : 1'b0, ratio);
  endtask

  task automatic settle;
    repeat (12) @(negedge i_CLK);
  endtask

  task automatic test_reset;
    i_RST = 1'b1;
    repeat (4) @(negedge i_CLK);
    total++; if (o_SCC !== 16'h0)    begin bad++; $display("FAIL reset_scc: got=%h exp=0000", o_SCC); end
    total++; if (o_PSG !== 16'h0)    begin bad++; $display("FAIL reset_psg: got=%h exp=0000", o_PSG); end
    total++; if (o_OPLL !== 16'h0)   begin bad++; $display("FAIL reset_opll: got=%h exp=0000", o_OPLL); end
    total++; if (o_ALL !== 16'h0)    begin bad++; $display("FAIL reset_all: got=%h exp=0000", o_ALL); end
    total++; if (o_VALID_R !== 1'b0) begin bad++; $display("FAIL reset_valid_r: got=%b exp=0", o_VALID_R); end
    total++; if (o_VALID_L !== 1'b0) begin bad++; $display("FAIL reset_valid_l: got=%b exp=0", o_VALID_L); end
    total++; if (o_FRAME_ERR !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got=%b exp=0", o_FRAME_ERR); end
    i_RST = 1'b0;
    settle();
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL reset_idle_events: got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_loopback;
    tx_word(1'b1, 16'h7FFE, 16'h1234, 16, 8);
    for (int f = 0; f < 2; f++) begin
      tx_word(1'b0, 16'h8001, 16'hFEDC, 16, 8);
      tx_word(1'b1, 16'h7FFE, 16'h1234, 16, 8);
    end
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL loopback_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL loopback_ev%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if ({o_SCC, o_PSG, o_OPLL, o_ALL} !== 64'h8001_7FFE_1234_FEDC)
      begin bad++; $display("FAIL loopback_outputs: got=%h exp=8001_7ffe_1234_fedc", {o_SCC, o_PSG, o_OPLL, o_ALL}); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    tx_word(1'b0, 16'h1111, 16'h2222, 16, 8);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'($urandom), 1'($urandom), 8);
    i_RST = 1'b1;
    repeat (3) @(negedge i_CLK);
    i_RST = 1'b0;
    got_q.delete(); exp_q.delete();
    m_scc = 16'h0; m_psg = 16'h0; m_opll = 16'h0; m_all = 16'h0;
    m_vld = 1'b0; m_pend_short = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom), 1'($urandom), 8);
    m_prev_ws = 1'b1; m_vld = 1'b1;
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_partial_events: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    total++;
    if ({o_SCC, o_PSG, o_OPLL, o_ALL} !== {m_scc, m_psg, m_opll, m_all})
      begin bad++; $display("FAIL rstmid_partial_outputs: got=%h exp=%h", {o_SCC, o_PSG, o_OPLL, o_ALL}, {m_scc, m_psg, m_opll, m_all}); end
    tx_word(1'b0, 16'hA5A5, 16'h5A5A, 16, 8);
    tx_word(1'b1, 16'h0F0F, 16'hF0F0, 16, 8);
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_ev%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_word;
    tx_word(1'b0, 16'($urandom), 16'($urandom), 10, 8);
    tx_word(1'b1, 16'h3C3C, 16'hC3C3, 16, 8);
    settle();
    total++;
    if ({o_SCC, o_ALL} !== {m_scc, m_all})
      begin bad++; $display("FAIL short_outputs_held: got=%h exp=%h", {o_SCC, o_ALL}, {m_scc, m_all}); end
    tx_word(1'b0, 16'h1357, 16'h2468, 16, 8);
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL short_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL short_ev%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_long_word;
    tx_word(1'b1, 16'hBEEF, 16'h4321, 18, 8);
    tx_word(1'b0, 16'h0101, 16'h8080, 16, 8);
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL long_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL long_ev%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if ({o_SCC, o_PSG, o_OPLL, o_ALL} !== {m_scc, m_psg, m_opll, m_all})
      begin bad++; $display("FAIL long_outputs: got=%h exp=%h", {o_SCC, o_PSG, o_OPLL, o_ALL}, {m_scc, m_psg, m_opll, m_all}); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sign_extremes;
    tx_word(1'b1, 16'h7FFF, 16'h7FFF, 16, 8);
    tx_word(1'b0, 16'h8000, 16'h8000, 16, 8);
    tx_word(1'b1, 16'h8000, 16'h7FFF, 16, 8);
    tx_word(1'b0, 16'h7FFF, 16'h8000, 16, 8);
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sign_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sign_ev%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if ({o_SCC, o_PSG, o_OPLL, o_ALL} !== 64'h7FFF_8000_7FFF_8000)
      begin bad++; $display("FAIL sign_outputs: got=%h exp=7fff_8000_7fff_8000", {o_SCC, o_PSG, o_OPLL, o_ALL}); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_min_ratio;
    for (int f = 0; f < 300; f++) begin
      tx_word(1'b1, 16'($urandom), 16'($urandom), 16, 4);
      tx_word(1'b0, 16'($urandom), 16'($urandom), 16, 4);
    end
    settle();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count: got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_ev%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if ({o_SCC, o_PSG, o_OPLL, o_ALL} !== {m_scc, m_psg, m_opll, m_all})
      begin bad++; $display("FAIL random_outputs: got=%h exp=%h", {o_SCC, o_PSG, o_OPLL, o_ALL}, {m_scc, m_psg, m_opll, m_all}); end
    total++;
    if (overlap_cnt != 0) begin bad++; $display("FAIL pulse_overlap: got=%0d exp=0", overlap_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_reset_mid();
    test_short_word();
    test_long_word();
    test_sign_extremes();
    test_random_min_ratio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
